bus_router: RTL and testbench

Parametrised single-master address router for the mini SoC core bus: it decodes a native valid/ready core request onto one of `SLV_NUM` slave ports using per-slave base/mask regions. Unlike the flat combinational decoder it replaces, it registers the slave select and the response, and it bounds every access with a timeout counter. Unmapped accesses and timed-out accesses complete with an error response instead of hanging the core. It sits between the CPU core and the native-IP, memory-mapped-IP, SRAM and PSRAM subsystems.

---
 rtl/bus_router_pkg.sv | 27 ++
 rtl/bus_router_dec.sv | 29 ++
 rtl/bus_router.sv | 136 +++++++++++++
 tb/tb_bus_router.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_router_pkg.sv
// Shared types, error codes and region match helper for the bus_router slice.
package bus_router_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      ERR  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_DECODE  = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } err_cause_e;

   localparam err_cause_e ERR_NONE    = CAUSE_NONE;
   localparam err_cause_e ERR_DECODE  = CAUSE_DECODE;
   localparam err_cause_e ERR_TIMEOUT = CAUSE_TIMEOUT;

   function automatic logic region_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/bus_router_dec.sv
// Combinational priority decoder: address -> (hit, slave index), lowest index wins.
// Zero latency, no flow control; the parent samples the result while in IDLE.
module bus_router_dec
   import bus_router_pkg::*;
#(
   parameter int                    SLV_NUM  = 4,
   parameter logic [SLV_NUM*32-1:0] SLV_BASE = {32'h0400_0000, 32'h0300_0000,
                                                32'h0000_0000, 32'h1000_0000},
   parameter logic [SLV_NUM*32-1:0] SLV_MASK = {SLV_NUM{32'hFF00_0000}},
   localparam int                   IDX_W    = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1
) (
   input  logic [31:0]      i_addr,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_idx
);

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int i = SLV_NUM - 1; i >= 0; i--) begin
         if (region_hit(i_addr, SLV_BASE[i*32 +: 32], SLV_MASK[i*32 +: 32])) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bus_router.sv
// Single-master core-bus router with registered select/response, timeout abort and error reporting.
// Hit latency 2 cycles minimum (decode + registered response); the core is held until the slave or timeout completes.
module bus_router
   import bus_router_pkg::*;
#(
   parameter int                    SLV_NUM     = 4,
   parameter logic [SLV_NUM*32-1:0] SLV_BASE    = {32'h0400_0000, 32'h0300_0000,
                                                   32'h0000_0000, 32'h1000_0000},
   parameter logic [SLV_NUM*32-1:0] SLV_MASK    = {SLV_NUM{32'hFF00_0000}},
   parameter int                    TIMEOUT_CYC = 1023,
   parameter logic [31:0]           ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  core_valid_i,
   input  logic [31:0]           core_addr_i,
   input  logic [31:0]           core_wdata_i,
   input  logic [3:0]            core_wstrb_i,
   output logic [31:0]           core_rdata_o,
   output logic                  core_ready_o,
   output logic [SLV_NUM-1:0]    slv_valid_o,
   output logic [31:0]           slv_addr_o,
   output logic [31:0]           slv_wdata_o,
   output logic [3:0]            slv_wstrb_o,
   input  logic [SLV_NUM*32-1:0] slv_rdata_i,
   input  logic [SLV_NUM-1:0]    slv_ready_i,
   output logic                  err_o,
   output logic [1:0]            err_cause_o,
   output logic [31:0]           err_addr_o
);

   localparam int               IDX_W   = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
   localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   state_e             r_state;
   logic [IDX_W-1:0]   r_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_rdata;
   logic               r_ready;
   logic               r_err;
   err_cause_e         r_err_cause;
   logic [31:0]        r_err_addr;
   logic [SLV_NUM-1:0] r_slv_valid;

   logic               w_hit;
   logic [IDX_W-1:0]   w_idx;
   logic               w_sel_ready;
   logic [31:0]        w_sel_rdata;

   bus_router_dec #(
      .SLV_NUM  (SLV_NUM),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .i_addr (core_addr_i),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   // Only the registered target is listened to; other slaves' ready is ignored.
   assign w_sel_ready = slv_ready_i[r_sel];
   assign w_sel_rdata = slv_rdata_i[32*r_sel +: 32];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_rdata     <= '0;
         r_ready     <= 1'b0;
         r_err       <= 1'b0;
         r_err_cause <= ERR_NONE;
         r_err_addr  <= '0;
         r_slv_valid <= '0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (core_valid_i) begin
                  r_addr <= core_addr_i;
                  r_cnt  <= '0;
                  if (w_hit) begin
                     r_sel              <= w_idx;
                     r_slv_valid        <= '0;
                     r_slv_valid[w_idx] <= 1'b1;
                     r_state            <= BUSY;
                  end else begin
                     r_ready     <= 1'b1;
                     r_rdata     <= ERR_RDATA;
                     r_err       <= 1'b1;
                     r_err_cause <= ERR_DECODE;
                     r_err_addr  <= core_addr_i;
                     r_state     <= ERR;
                  end
               end
            end
            BUSY: begin
               if (w_sel_ready) begin
                  r_rdata     <= w_sel_rdata;
                  r_ready     <= 1'b1;
                  r_slv_valid <= '0;
                  r_state     <= RESP;
               end else if (r_cnt == CNT_MAX) begin
                  r_rdata     <= ERR_RDATA;
                  r_ready     <= 1'b1;
                  r_err       <= 1'b1;
                  r_err_cause <= ERR_TIMEOUT;
                  r_err_addr  <= r_addr;
                  r_slv_valid <= '0;
                  r_state     <= ERR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP:    r_state <= IDLE;
            ERR:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign core_rdata_o = r_rdata;
   assign core_ready_o = r_ready;
   assign err_o        = r_err;
   assign err_cause_o  = r_err_cause;
   assign err_addr_o   = r_err_addr;
   assign slv_valid_o  = r_slv_valid;
   assign slv_addr_o   = core_addr_i;
   assign slv_wdata_o  = core_wdata_i;
   assign slv_wstrb_o  = (r_state == BUSY) ? core_wstrb_i : 4'b0000;

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router with a response scoreboard and per-cycle slave-side checks.
module tb_bus_router;

   localparam int          NS  = 4;
   localparam int          TO  = 8;
   localparam logic [31:0] ERD = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  cause;
      logic [31:0] eaddr;
   } exp_t;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            core_valid_i;
   logic [31:0]     core_addr_i;
   logic [31:0]     core_wdata_i;
   logic [3:0]      core_wstrb_i;
   logic [31:0]     core_rdata_o;
   logic            core_ready_o;
   logic [NS-1:0]   slv_valid_o;
   logic [31:0]     slv_addr_o;
   logic [31:0]     slv_wdata_o;
   logic [3:0]      slv_wstrb_o;
   logic [NS*32-1:0] slv_rdata_i;
   logic [NS-1:0]   slv_ready_i;
   logic            err_o;
   logic [1:0]      err_cause_o;
   logic [31:0]     err_addr_o;

   logic [31:0] sdata [NS];
   exp_t        sb_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [1:0]  last_cause = 2'd0;
   logic [31:0] last_eaddr = 32'h0;

   bus_router #(
      .SLV_NUM     (NS),
      .SLV_BASE    ({32'h0400_0000, 32'h0300_0000, 32'h0000_0000, 32'h1000_0000}),
      .SLV_MASK    ({NS{32'hFF00_0000}}),
      .TIMEOUT_CYC (TO),
      .ERR_RDATA   (ERD)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .core_valid_i (core_valid_i),
      .core_addr_i  (core_addr_i),
      .core_wdata_i (core_wdata_i),
      .core_wstrb_i (core_wstrb_i),
      .core_rdata_o (core_rdata_o),
      .core_ready_o (core_ready_o),
      .slv_valid_o  (slv_valid_o),
      .slv_addr_o   (slv_addr_o),
      .slv_wdata_o  (slv_wdata_o),
      .slv_wstrb_o  (slv_wstrb_o),
      .slv_rdata_i  (slv_rdata_i),
      .slv_ready_i  (slv_ready_i),
      .err_o        (err_o),
      .err_cause_o  (err_cause_o),
      .err_addr_o   (err_addr_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // exp_sel < 0 means unmapped; stall < 0 means the slave never answers.
   task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int exp_sel, input int stall,
                         input logic [3:0] noise, input int exp_lat);
      exp_t       e;
      exp_t       got;
      logic [3:0] oh;
      logic       tmo;
      logic       done;
      oh  = (exp_sel >= 0) ? (4'b0001 << exp_sel) : 4'b0000;
      tmo = (exp_sel >= 0) && (stall < 0 || stall > TO);
      e.err   = (exp_sel < 0) || tmo;
      e.rdata = e.err ? ERD : sdata[exp_sel];
      e.cause = (exp_sel < 0) ? 2'd1 : (tmo ? 2'd2 : last_cause);
      e.eaddr = e.err ? addr : last_eaddr;
      if (e.err) begin
         last_cause = e.cause;
         last_eaddr = addr;
      end
      sb_q.push_back(e);

      core_valid_i = 1'b1;
      core_addr_i  = addr;
      core_wdata_i = wdata;
      core_wstrb_i = wstrb;
      slv_ready_i  = noise;
      chk({tag, " idle valid"}, 32'(slv_valid_o), 32'h0);
      chk({tag, " idle wstrb"}, 32'(slv_wstrb_o), 32'h0);

      done = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
         step();
         if (core_ready_o) begin
            done = 1'b1;
            got  = sb_q.pop_front();
            chk({tag, " latency"}, 32'(c), 32'(exp_lat));
            chk({tag, " rdata"}, core_rdata_o, got.rdata);
            chk({tag, " err_o"}, 32'(err_o), 32'(got.err));
            chk({tag, " cause"}, 32'(err_cause_o), 32'(got.cause));
            chk({tag, " err_addr"}, err_addr_o, got.eaddr);
            chk({tag, " resp valid"}, 32'(slv_valid_o), 32'h0);
            chk({tag, " resp wstrb"}, 32'(slv_wstrb_o), 32'h0);
            core_valid_i = 1'b0;
            core_wstrb_i = 4'b0000;
            slv_ready_i  = 4'b0000;
         end else begin
            chk({tag, " busy valid"}, 32'(slv_valid_o), 32'(oh));
            chk({tag, " busy wstrb"}, 32'(slv_wstrb_o), 32'(wstrb));
            chk({tag, " busy addr"}, slv_addr_o, addr);
            chk({tag, " busy wdata"}, slv_wdata_o, wdata);
            chk({tag, " busy err_o"}, 32'(err_o), 32'h0);
            // Busy cycle index is c-1; the slave answers once its stall has elapsed.
            if (exp_sel >= 0 && stall >= 0 && (c - 1) >= stall)
               slv_ready_i = noise | oh;
            else
               slv_ready_i = noise;
         end
      end
      if (!done) begin
         chk({tag, " response timeout"}, 32'(core_ready_o), 32'h1);
         void'(sb_q.pop_front());
         core_valid_i = 1'b0;
         slv_ready_i  = 4'b0000;
      end
      step();
      chk({tag, " dead ready"}, 32'(core_ready_o), 32'h0);
      chk({tag, " dead err_o"}, 32'(err_o), 32'h0);
   endtask

   initial begin
      sdata[0] = 32'h1111_1111;
      sdata[1] = 32'h2222_2222;
      sdata[2] = 32'h1234_5678;
      sdata[3] = 32'h4444_4444;
      slv_rdata_i  = {sdata[3], sdata[2], sdata[1], sdata[0]};
      rst_n_i      = 1'b0;
      core_valid_i = 1'b0;
      core_addr_i  = 32'h0;
      core_wdata_i = 32'h0;
      core_wstrb_i = 4'b0000;
      slv_ready_i  = 4'b0000;
      step();
      step();
      chk("rst core_ready", 32'(core_ready_o), 32'h0);
      chk("rst core_rdata", core_rdata_o, 32'h0);
      chk("rst slv_valid", 32'(slv_valid_o), 32'h0);
      chk("rst slv_wstrb", 32'(slv_wstrb_o), 32'h0);
      chk("rst err_o", 32'(err_o), 32'h0);
      chk("rst err_cause", 32'(err_cause_o), 32'h0);
      chk("rst err_addr", err_addr_o, 32'h0);
      rst_n_i = 1'b1;
      step();

      access("rd_s2",     32'h0300_0010, 32'h0,          4'b0000,  2,  0, 4'b0000,  2);
      access("wr_s1",     32'h0000_0004, 32'hCAFE_0001,  4'b0011,  1,  5, 4'b0000,  7);
      access("miss",      32'h7000_0000, 32'h5555_5555,  4'b1111, -1,  0, 4'b0000,  1);
      access("timeout",   32'h0400_0020, 32'h0,          4'b0000,  3, -1, 4'b0000, TO + 2);
      access("after_to",  32'h1000_0100, 32'h0,          4'b0000,  0,  1, 4'b0000,  3);
      access("rdy_limit", 32'h0300_0040, 32'h0,          4'b0000,  2, TO, 4'b0000, TO + 2);
      access("noise",     32'h00AB_CD00, 32'hBEEF_0002,  4'b1000,  1,  3, 4'b1101,  5);

      // Reset during the third busy cycle must abort silently.
      core_valid_i = 1'b1;
      core_addr_i  = 32'h0400_0000;
      core_wdata_i = 32'h7777_7777;
      core_wstrb_i = 4'b1111;
      step();
      chk("rst_busy1 valid", 32'(slv_valid_o), 32'h8);
      step();
      step();
      chk("rst_busy3 wstrb", 32'(slv_wstrb_o), 32'hF);
      rst_n_i = 1'b0;
      step();
      chk("abort core_ready", 32'(core_ready_o), 32'h0);
      chk("abort core_rdata", core_rdata_o, 32'h0);
      chk("abort slv_valid", 32'(slv_valid_o), 32'h0);
      chk("abort slv_wstrb", 32'(slv_wstrb_o), 32'h0);
      chk("abort err_o", 32'(err_o), 32'h0);
      chk("abort err_cause", 32'(err_cause_o), 32'h0);
      chk("abort err_addr", err_addr_o, 32'h0);
      last_cause   = 2'd0;
      last_eaddr   = 32'h0;
      rst_n_i      = 1'b1;
      core_valid_i = 1'b0;
      core_wstrb_i = 4'b0000;
      step();
      chk("post_abort ready", 32'(core_ready_o), 32'h0);

      access("fresh", 32'h0300_0100, 32'h0, 4'b0000, 2, 0, 4'b0000, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
